// File: rtl/uart_rx_fifo.sv
// 8N1 oversampling UART receiver feeding a small FIFO with a valid/ready byte output.
// The receiver reports bad stop bits with a one-cycle pulse and flags bytes dropped by a full FIFO.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | counting to mid start bit, rejecting glitches
// DATA      | sampling 8 data bits, LSB first
// STOP      | sampling mid stop bit, push or frame error
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         uart_rx_i,
    output logic [7:0]                   rx_data_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         frame_err_o,
    output logic                         overflow_o,
    input  logic                         clear_i
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            sync1, rx_s;
    logic            push, frame_err;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   count;
    logic            full, do_push, do_pop, drop;

    // Synchronizer idles high so reset never fakes a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            sync1   <= uart_rx_i;
            rx_s    <= sync1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        push      = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_CNT) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push to a full FIFO is kept.
    assign do_pop  = rx_valid_o && rx_ready_i;
    assign full    = (count == FULL_LVL);
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + LW'(1);
            else if (!do_push && do_pop) count <= count - LW'(1);
            if (drop)         overflow_o <= 1'b1;
            else if (clear_i) overflow_o <= 1'b0;
        end
    end

    assign rx_data_o   = mem[rd_ptr];
    assign rx_valid_o  = (count != '0);
    assign level_o     = count;
    assign frame_err_o = frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=4, DEPTH=4.
// Serial frames are driven bit by bit; popped bytes and error pulses are logged by a monitor.
module tb_uart_rx_fifo;

    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       uart_rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [2:0] level_o;
    logic       frame_err_o;
    logic       overflow_o;
    logic       clear_i;

    int total = 0;
    int bad   = 0;

    logic [7:0] popped [$];
    int         err_cnt   = 0;
    int         valid_cyc = 0;
    int         pop_base, err_base, vld_base;

    uart_rx_fifo #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .uart_rx_i   (uart_rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .level_o     (level_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .clear_i     (clear_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (rx_valid_o && rx_ready_i) popped.push_back(rx_data_o);
            if (frame_err_o) err_cnt++;
            if (rx_valid_o) valid_cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rx_i = v;
        cycles(C);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    function automatic logic [7:0] pop_at(input int idx);
        if (idx < popped.size()) return popped[idx];
        return 8'hxx;
    endfunction

    task automatic snap();
        pop_base = popped.size();
        err_base = err_cnt;
        vld_base = valid_cyc;
    endtask

    initial begin
        rst_i      = 1'b1;
        uart_rx_i  = 1'b1;
        rx_ready_i = 1'b0;
        clear_i    = 1'b0;
        cycles(3);
        chk("rst_valid", 32'(rx_valid_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_data", 32'(rx_data_o), 32'h00);
        chk("rst_ferr", 32'(frame_err_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        rst_i = 1'b0;
        cycles(4);

        // single byte, consumer always ready
        rx_ready_i = 1'b1;
        snap();
        send_frame(8'h55, 1'b1);
        cycles(8);
        chk("t1_npop", 32'(popped.size() - pop_base), 32'd1);
        chk("t1_data", 32'(pop_at(pop_base)), 32'h55);
        chk("t1_vcyc", 32'(valid_cyc - vld_base), 32'd1);
        chk("t1_ferr", 32'(err_cnt - err_base), 32'd0);
        chk("t1_level", 32'(level_o), 32'd0);

        // back-to-back bytes held in FIFO, then drained in order
        rx_ready_i = 1'b0;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        cycles(8);
        chk("t2_level", 32'(level_o), 32'd3);
        chk("t2_valid", 32'(rx_valid_o), 32'd1);
        chk("t2_head", 32'(rx_data_o), 32'hA5);
        snap();
        rx_ready_i = 1'b1;
        cycles(6);
        rx_ready_i = 1'b0;
        chk("t2_npop", 32'(popped.size() - pop_base), 32'd3);
        chk("t2_pop0", 32'(pop_at(pop_base)), 32'hA5);
        chk("t2_pop1", 32'(pop_at(pop_base + 1)), 32'h00);
        chk("t2_pop2", 32'(pop_at(pop_base + 2)), 32'hFF);
        chk("t2_empty", 32'(rx_valid_o), 32'd0);
        chk("t2_ovf", 32'(overflow_o), 32'd0);

        // overflow: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        cycles(8);
        chk("t3_level", 32'(level_o), 32'd4);
        chk("t3_ovf", 32'(overflow_o), 32'd1);
        chk("t3_head", 32'(rx_data_o), 32'h01);
        clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0;
        chk("t3_clear", 32'(overflow_o), 32'd0);
        chk("t3_lvl2", 32'(level_o), 32'd4);
        snap();
        rx_ready_i = 1'b1;
        cycles(8);
        chk("t3_npop", 32'(popped.size() - pop_base), 32'd4);
        chk("t3_pop0", 32'(pop_at(pop_base)), 32'h01);
        chk("t3_pop3", 32'(pop_at(pop_base + 3)), 32'h04);

        // framing error followed by a long break, then a good byte
        snap();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'(8'h3C >> i));
        uart_rx_i = 1'b0;
        cycles(100);
        chk("t4_ferr_brk", 32'(err_cnt - err_base), 32'd1);
        chk("t4_nopush", 32'(popped.size() - pop_base), 32'd0);
        uart_rx_i = 1'b1;
        cycles(8);
        send_frame(8'h81, 1'b1);
        cycles(8);
        chk("t4_ferr", 32'(err_cnt - err_base), 32'd1);
        chk("t4_npop", 32'(popped.size() - pop_base), 32'd1);
        chk("t4_data", 32'(pop_at(pop_base)), 32'h81);
        chk("t4_level", 32'(level_o), 32'd0);

        // one-cycle glitch on an idle line
        snap();
        uart_rx_i = 1'b0;
        cycles(1);
        uart_rx_i = 1'b1;
        cycles(12);
        chk("t5_level", 32'(level_o), 32'd0);
        chk("t5_ferr", 32'(err_cnt - err_base), 32'd0);
        chk("t5_npop", 32'(popped.size() - pop_base), 32'd0);
        chk("t5_valid", 32'(rx_valid_o), 32'd0);

        // async reset during bit 4 with one byte already queued
        rx_ready_i = 1'b0;
        send_frame(8'h5A, 1'b1);
        cycles(8);
        chk("t6_pre_lvl", 32'(level_o), 32'd1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h7E >> i));
        uart_rx_i = 1'b1;
        cycles(2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_lvl", 32'(level_o), 32'd0);
        chk("t6_rst_vld", 32'(rx_valid_o), 32'd0);
        chk("t6_rst_data", 32'(rx_data_o), 32'h00);
        chk("t6_rst_ferr", 32'(frame_err_o), 32'd0);
        cycles(12);
        rst_i = 1'b0;
        cycles(4);
        rx_ready_i = 1'b1;
        snap();
        send_frame(8'h7E, 1'b1);
        cycles(8);
        chk("t6_npop", 32'(popped.size() - pop_base), 32'd1);
        chk("t6_data", 32'(pop_at(pop_base)), 32'h7E);
        chk("t6_ferr", 32'(err_cnt - err_base), 32'd0);
        chk("t6_level", 32'(level_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
